// File: rtl/afifo_rd_burst_drain.sv
//------------------------------------------------------------------------------
// afifo_rd_burst_drain
//
// Read-side drain controller for the dual-clock asynchronous FIFO. Lives
// entirely in the RClk domain. It pulls words out of the FIFO read port and
// presents them as a valid/ready stream framed into bursts of BURST_LEN words.
// Consecutive bursts are separated by GAP_CYCLES idle cycles.
//
// The FIFO read port has a registered Data_out, so a word appears one cycle
// after its read is accepted. A 2-entry output buffer absorbs that latency. A
// credit rule keeps the buffer from overflowing while still sustaining one
// word per cycle.
//
// Parameters
//   DATA_WIDTH  FIFO word width
//   BURST_LEN   words per burst (>= 1); m_last marks word BURST_LEN-1
//   GAP_CYCLES  idle RClk cycles between bursts (0 = back-to-back)
//
// Ports
//   RClk        in   read-domain clock, shared with the FIFO read port
//   PresetFull  in   asynchronous, active-high reset
//   en          in   burst enable, sampled only where a new burst could start
//   fifo_data   in   FIFO Data_out, valid the cycle after an accepted read
//   fifo_empty  in   FIFO Empty flag
//   fifo_rd_en  out  FIFO ReadEn (combinational)
//   m_data      out  stream data (head of the output buffer)
//   m_valid     out  stream valid (output buffer not empty)
//   m_ready     in   stream ready
//   m_last      out  final word of the current burst
//   busy        out  controller is in any state other than IDLE
//------------------------------------------------------------------------------
module afifo_rd_burst_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 16,
    parameter int GAP_CYCLES = 4
) (
    input  logic                  RClk,
    input  logic                  PresetFull,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy
);

    localparam int IW = $clog2(BURST_LEN + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [IW-1:0] ISSUE_END  = IW'(BURST_LEN);
    localparam logic [IW-1:0] ISSUE_LAST = IW'(BURST_LEN - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Control state
    state_t          state_q,     state_d;
    logic [IW-1:0]   issue_cnt_q, issue_cnt_d;
    logic [GW-1:0]   gap_cnt_q,   gap_cnt_d;

    // Read in flight: the FIFO presents its word on fifo_data this cycle
    logic            inflight_q,      inflight_d;
    logic            inflight_last_q, inflight_last_d;

    // 2-entry output buffer
    logic [DATA_WIDTH-1:0] buf_data_q [2];
    logic [DATA_WIDTH-1:0] buf_data_d [2];
    logic [1:0]            buf_last_q,  buf_last_d;
    logic                  rd_ptr_q,    rd_ptr_d;
    logic                  wr_ptr_q,    wr_ptr_d;
    logic [1:0]            occ_q,       occ_d;

    // Handshake and credit signals
    logic       pop;
    logic       push;
    logic       rd_accept;
    logic [2:0] committed;
    logic       has_credit;
    logic       issue_room;
    logic       issue_last;

    //--------------------------------------------------------------------------
    // Stream outputs come straight from registers
    //--------------------------------------------------------------------------
    assign m_valid = (occ_q != 2'd0);
    assign m_data  = buf_data_q[rd_ptr_q];
    // A stale tag may remain in an emptied slot, so qualify it with m_valid.
    assign m_last  = buf_last_q[rd_ptr_q] & m_valid;
    assign busy    = (state_q != ST_IDLE);

    assign pop  = m_valid & m_ready;
    assign push = inflight_q;

    // Words already committed to the buffer once this cycle's pop is taken:
    // those held in the buffer plus the word arriving now. A new read is
    // allowed only if its word is sure to find a free slot next cycle.
    assign committed  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign has_credit = (committed < 3'd2);
    assign issue_room = (issue_cnt_q < ISSUE_END);
    assign issue_last = (issue_cnt_q == ISSUE_LAST);

    assign fifo_rd_en = (state_q == ST_READ) & ~fifo_empty & issue_room & has_credit;
    assign rd_accept  = fifo_rd_en & ~fifo_empty;

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave one
        // unassigned and infer a latch.
        state_d         = state_q;
        issue_cnt_d     = issue_cnt_q;
        gap_cnt_d       = gap_cnt_q;
        inflight_d      = rd_accept;
        inflight_last_d = rd_accept & issue_last;
        buf_data_d      = buf_data_q;
        buf_last_d      = buf_last_q;
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;
        occ_d           = occ_q + {1'b0, push} - {1'b0, pop};

        // Capture the word returned by last cycle's read, with its last tag.
        if (push) begin
            buf_data_d[wr_ptr_q] = fifo_data;
            buf_last_d[wr_ptr_q] = inflight_last_q;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d     = ST_READ;
                    issue_cnt_d = '0;
                end
            end

            ST_READ: begin
                // en is ignored here: a started burst always runs to its end.
                if (rd_accept) begin
                    issue_cnt_d = issue_cnt_q + IW'(1);
                    if (issue_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                // The last-tagged word is the final one issued, so its
                // handshake means the buffer has fully drained.
                if (pop & m_last) begin
                    if (GAP_CYCLES > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                    end else if (en) begin
                        state_d     = ST_READ;
                        issue_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    if (en) begin
                        state_d     = ST_READ;
                        issue_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // State registers
    //--------------------------------------------------------------------------
    // NOTE: state updates use non-blocking assignments, so every flop samples
    // the values from before this clock edge, whatever the statement order.
    always_ff @(posedge RClk or posedge PresetFull) begin
        if (PresetFull) begin
            state_q         <= ST_IDLE;
            issue_cnt_q     <= '0;
            gap_cnt_q       <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            // NOTE: the two buffer slots are reset as well. m_data is read
            // straight from the head slot and must be 0 during reset.
            buf_data_q[0]   <= '0;
            buf_data_q[1]   <= '0;
            buf_last_q      <= '0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            occ_q           <= '0;
        end else begin
            state_q         <= state_d;
            issue_cnt_q     <= issue_cnt_d;
            gap_cnt_q       <= gap_cnt_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            buf_data_q      <= buf_data_d;
            buf_last_q      <= buf_last_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            occ_q           <= occ_d;
        end
    end

endmodule

// File: tb/tb_afifo_rd_burst_drain.sv
//------------------------------------------------------------------------------
// Testbench for afifo_rd_burst_drain.
//
// A behavioural FIFO read port (queue plus registered Data_out) feeds the DUT.
// Each word written into the model FIFO is also pushed onto a scoreboard
// queue, tagged with its expected m_last. Words are popped from the
// scoreboard and compared on every stream handshake. A second instance with
// BURST_LEN=1 and GAP_CYCLES=0 covers the single-word burst case.
//------------------------------------------------------------------------------
module tb_afifo_rd_burst_drain;

    localparam int DW  = 8;
    localparam int BL  = 16;
    localparam int GAP = 4;

    logic RClk = 1'b0;
    always #5 RClk = ~RClk;

    // Main DUT (BURST_LEN=16, GAP_CYCLES=4)
    logic          PresetFull, en, fifo_empty, m_ready;
    logic          fifo_rd_en, m_valid, m_last, busy;
    logic [DW-1:0] fifo_data, m_data;

    afifo_rd_burst_drain #(.DATA_WIDTH(DW), .BURST_LEN(BL), .GAP_CYCLES(GAP)) u_dut (
        .RClk       (RClk),
        .PresetFull (PresetFull),
        .en         (en),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .busy       (busy)
    );

    // Single-word-burst DUT (BURST_LEN=1, GAP_CYCLES=0)
    logic          rst1, en1, fe1, rdy1, re1, mv1, ml1, bz1;
    logic [DW-1:0] fd1, md1;

    afifo_rd_burst_drain #(.DATA_WIDTH(DW), .BURST_LEN(1), .GAP_CYCLES(0)) u_dut1 (
        .RClk       (RClk),
        .PresetFull (rst1),
        .en         (en1),
        .fifo_data  (fd1),
        .fifo_empty (fe1),
        .fifo_rd_en (re1),
        .m_data     (md1),
        .m_valid    (mv1),
        .m_ready    (rdy1),
        .m_last     (ml1),
        .busy       (bz1)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    // Scenario record: stimulus knobs followed by the expected results.
    typedef struct {
        string name;
        int    preload;          // words in the FIFO before en rises
        int    late_n;           // words written later
        int    late_at;          // cycle of the late write (-1 = none)
        int    rmode;            // 0 ready high, 1 toggle, 2 low until rel_at
        int    rel_at;
        int    drop_at;          // cycle at which en falls (-1 = never)
        int    probe_at;         // cycle of the mid-run probe (-1 = none)
        int    exp_probe_reads;
        logic  exp_probe_busy;
        logic  exp_probe_rd;
        int    exp_words;
        logic  exp_busy_end;
    } vec_t;

    exp_t          exp_q[$];
    logic [DW-1:0] src_q[$];
    int            pop_cyc[$];

    int  checks   = 0;
    int  failures = 0;
    int  cyc, exp_idx, words, reads, out_cnt, max_out, first_rd, first_val;
    int  rmode, rel_at, late_at, late_n, drop_at;
    bit  acc, pop;
    logic [DW-1:0] next_val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Write one word into the model FIFO and record its expected framing.
    task automatic push_word();
        src_q.push_back(next_val);
        exp_q.push_back('{data: next_val, last: ((exp_idx % BL) == BL - 1)});
        exp_idx++;
        next_val++;
    endtask

    // One RClk cycle. Inputs change 1 ns after the rising edge. Outputs are
    // sampled on the falling edge, along with the read/pop that the next
    // rising edge will commit.
    task automatic step_cycle();
        @(posedge RClk);
        #1;
        if (acc) fifo_data = src_q.pop_front();
        if (cyc == drop_at) en = 1'b0;
        if (cyc == late_at) repeat (late_n) push_word();
        fifo_empty = (src_q.size() == 0);
        case (rmode)
            0:       m_ready = 1'b1;
            1:       m_ready = ((cyc % 2) == 0);
            default: m_ready = (cyc >= rel_at);
        endcase
        cyc++;
        @(negedge RClk);
        acc = fifo_rd_en & ~fifo_empty;
        pop = m_valid & m_ready;
        if (fifo_rd_en && first_rd < 0) first_rd = cyc;
        if (m_valid && first_val < 0) first_val = cyc;
        if (acc) reads++;
        if (pop) begin
            pop_cyc.push_back(cyc);
            words++;
            check("word_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("m_data", m_data, e.data);
                check("m_last", m_last, e.last);
            end
        end
        out_cnt = out_cnt + int'(acc) - int'(pop);
        if (out_cnt > max_out) max_out = out_cnt;
    endtask

    // Reset the main DUT and the model, preload the FIFO, then release with en=1.
    task automatic start(input int preload);
        PresetFull = 1'b1;
        en         = 1'b0;
        m_ready    = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        src_q.delete();
        exp_q.delete();
        pop_cyc.delete();
        exp_idx = 0; next_val = '0; acc = 0; pop = 0; cyc = 0;
        words = 0; reads = 0; out_cnt = 0; max_out = 0;
        first_rd = -1; first_val = -1;
        late_at = -1; late_n = 0; drop_at = -1; rel_at = 0; rmode = 0;
        repeat (2) @(negedge RClk);
        repeat (preload) push_word();
        fifo_empty = (src_q.size() == 0);
        PresetFull = 1'b0;
        en         = 1'b1;
    endtask

    vec_t          vecs[4];
    vec_t          v;
    int            idle;
    logic [DW-1:0] q1[$];
    logic [DW-1:0] exp1_q[$];
    logic [DW-1:0] e1;
    bit            acc1;
    int            n1;

    initial begin
        vecs[0] = '{"toggle",    16,  0, -1, 1,  0, -1, -1, 0, 1'b0, 1'b0, 16, 1'b1};
        vecs[1] = '{"stall",      5, 11, 20, 0,  0, -1, 18, 5, 1'b1, 1'b0, 16, 1'b1};
        vecs[2] = '{"en_drop",   16,  0, -1, 0,  0,  3, -1, 0, 1'b0, 1'b0, 16, 1'b0};
        vecs[3] = '{"ready_low",  6,  0, -1, 2, 40, -1, 20, 2, 1'b1, 1'b0,  6, 1'b1};

        // ---- Reset state, with active inputs held to provoke any leak ----
        rst1 = 1'b1; en1 = 1'b0; fe1 = 1'b1; rdy1 = 1'b0; fd1 = '0;
        PresetFull = 1'b1; en = 1'b1; fifo_empty = 1'b0; m_ready = 1'b1; fifo_data = 8'hAA;
        repeat (3) @(negedge RClk);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_data", m_data, 0);
        check("rst_busy", busy, 0);
        check("rst_fifo_rd_en", fifo_rd_en, 0);
        check("rst1_m_valid", mv1, 0);

        // ---- Two back-to-back bursts from a preloaded FIFO ----
        start(32);
        rmode = 0;
        repeat (80) step_cycle();
        check("t1_words", words, 32);
        check("t1_first_latency", first_val - first_rd, 2);
        check("t1_burst0_contig", pop_cyc[15] - pop_cyc[0], 15);
        check("t1_burst1_contig", pop_cyc[31] - pop_cyc[16], 15);
        idle = pop_cyc[16] - pop_cyc[15] - 1;
        check("t1_gap_idle", (idle >= GAP) && (idle <= GAP + 3), 1);
        check("t1_max_outstanding", max_out <= 2, 1);
        check("t1_busy_end", busy, 1);
        check("t1_rd_en_end", fifo_rd_en, 0);

        // ---- Scenario table ----
        for (int r = 0; r < 4; r++) begin
            v = vecs[r];
            start(v.preload);
            rmode   = v.rmode;
            rel_at  = v.rel_at;
            late_at = v.late_at;
            late_n  = v.late_n;
            drop_at = v.drop_at;
            for (int c = 0; c < 120; c++) begin
                step_cycle();
                if (cyc == v.probe_at) begin
                    check($sformatf("%s_probe_reads", v.name), reads, v.exp_probe_reads);
                    check($sformatf("%s_probe_busy", v.name), busy, v.exp_probe_busy);
                    check($sformatf("%s_probe_rd_en", v.name), fifo_rd_en, v.exp_probe_rd);
                end
            end
            check($sformatf("%s_words", v.name), words, v.exp_words);
            check($sformatf("%s_scoreboard_empty", v.name), exp_q.size(), 0);
            check($sformatf("%s_max_outstanding", v.name), max_out <= 2, 1);
            check($sformatf("%s_busy_end", v.name), busy, v.exp_busy_end);
            check($sformatf("%s_rd_en_end", v.name), fifo_rd_en, 0);
        end

        // ---- Asynchronous reset with a full output buffer ----
        start(32);
        rmode  = 2;
        rel_at = 100000;
        repeat (8) step_cycle();
        check("ar_pre_valid", m_valid, 1);
        check("ar_pre_reads", reads, 2);
        check("ar_pre_busy", busy, 1);
        PresetFull = 1'b1;
        #1;
        check("ar_m_valid", m_valid, 0);
        check("ar_busy", busy, 0);
        check("ar_rd_en", fifo_rd_en, 0);
        check("ar_m_last", m_last, 0);
        // Buffered words are lost; the remaining FIFO contents form a fresh stream.
        exp_q.delete();
        exp_idx = 0;
        foreach (src_q[i]) begin
            exp_q.push_back('{data: src_q[i], last: ((exp_idx % BL) == BL - 1)});
            exp_idx++;
        end
        acc = 0; pop = 0; out_cnt = 0; max_out = 0; words = 0;
        #1;
        PresetFull = 1'b0;
        rmode = 0;
        repeat (100) step_cycle();
        check("ar_words", words, 30);
        check("ar_max_outstanding", max_out <= 2, 1);

        // ---- BURST_LEN=1, GAP_CYCLES=0: every word is a complete burst ----
        q1 = '{8'hA1, 8'hB2, 8'hC3};
        exp1_q = q1;
        @(negedge RClk);
        rst1 = 1'b0; en1 = 1'b1; rdy1 = 1'b1; fe1 = 1'b0; acc1 = 0; n1 = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge RClk);
            #1;
            if (acc1) fd1 = q1.pop_front();
            fe1 = (q1.size() == 0);
            @(negedge RClk);
            acc1 = re1 & ~fe1;
            if (mv1 & rdy1) begin
                n1++;
                check("b1_word_expected", exp1_q.size() != 0, 1);
                if (exp1_q.size() != 0) begin
                    e1 = exp1_q.pop_front();
                    check("b1_m_data", md1, e1);
                    check("b1_m_last", ml1, 1);
                end
            end
        end
        check("b1_words", n1, 3);
        check("b1_rd_en_end", re1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
